uart_tx_serializer: RTL



---
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the transmit FIFO and shifts each one
// out as an asynchronous serial frame: start bit, 8 data bits LSB first,
// optional even parity, then STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds a PARITY state that sends
// the XOR of the 8 data bits after the last data bit.
module uart_tx_serializer #(
    parameter int CLK_PER_BIT = 868,  // clocks per serial bit, >= 2
    parameter int STOP_BITS   = 1     // 1 or 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dataIn,
    input  logic       dataPresent,
    output logic       read,
    output logic       tx,
    output logic       busy
);
    localparam int            CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] baud, baud_nxt;    // clocks left in current bit, minus one
    logic [2:0]    idx, idx_nxt;      // data bit index, then stop bit index
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_nxt;      // running XOR of data bits already sent
`endif

    assign bit_end = (baud == '0);

    // State register; reset drops straight back to IDLE, abandoning any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: each non-idle state lasts whole bit times.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (dataPresent) state_nxt = START;
            START:  if (bit_end) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && idx == 3'd7) state_nxt = PARITY;
            PARITY: if (bit_end) state_nxt = STOP;
`else
            DATA:   if (bit_end && idx == 3'd7) state_nxt = STOP;
`endif
            STOP:   if (bit_end && idx == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values: baud reload per bit, shift/index advance at bit end.
    always_comb begin
        baud_nxt  = baud;
        idx_nxt   = idx;
        shift_nxt = shift;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par;
`endif
        if (state == IDLE) begin
            if (dataPresent) begin
                baud_nxt  = BAUD_LOAD;
                idx_nxt   = 3'd0;
                shift_nxt = dataIn;  // the only cycle dataIn is looked at
            end
        end else if (bit_end) begin
            baud_nxt = BAUD_LOAD;
            if (state == DATA) begin
                shift_nxt = shift >> 1;
`ifdef UART_TX_PARITY_EN
                par_nxt   = par ^ shift[0];
`endif
                // 7 -> 0 on the last data bit so STOP counts from zero
                idx_nxt   = idx + 3'd1;
            end else if (state == STOP) begin
                idx_nxt = (idx == STOP_LAST) ? 3'd0 : idx + 3'd1;
            end
        end else begin
            baud_nxt = baud - CW'(1);
        end
`ifdef UART_TX_PARITY_EN
        if (state == START) par_nxt = 1'b0;
`endif
    end

    // Output logic: read/busy decode the current state; tx is precomputed from
    // the next state so the registered line changes on the same edge as state.
    always_comb begin
        // gated with rst_n so a held reset never pops a byte it cannot latch
        read = (state == IDLE) && dataPresent && rst_n;
        busy = (state != IDLE);
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    // Datapath registers and the registered serial line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud  <= '0;
            idx   <= 3'd0;
            shift <= 8'h00;
            tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            baud  <= baud_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            tx    <= tx_nxt;
`ifdef UART_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

endmodule
